// File: rtl/fmap_col_serializer_if.sv
// Column-in / pixel-out handshake bundle for fmap_col_serializer.
// slave = serializer side, master = column source plus pixel sink.
interface fmap_col_serializer_if #(
    parameter int PIX_H  = 24,
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
);
    localparam int XW = $clog2(X_SIZE);
    localparam int YW = $clog2(Y_SIZE);

    logic                   col_valid;
    logic                   col_ready;
    logic [PIX_H-1:0][15:0] data_col;
    logic [XW-1:0]          x_origin;
    logic [YW-1:0]          y_origin;
    logic [2:0]             gain_shift;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [7:0]             pix_gray;
    logic [XW-1:0]          pix_x;
    logic [YW-1:0]          pix_y;
    logic                   pix_eoc;
    logic                   pix_eof;

    modport master (
        output col_valid, data_col, x_origin, y_origin, gain_shift, pix_ready,
        input  col_ready, pix_valid, pix_gray, pix_x, pix_y, pix_eoc, pix_eof
    );

    modport slave (
        input  col_valid, data_col, x_origin, y_origin, gain_shift, pix_ready,
        output col_ready, pix_valid, pix_gray, pix_x, pix_y, pix_eoc, pix_eof
    );
endinterface

// File: rtl/fmap_col_serializer.sv
// fp16 column to grayscale pixel stream, two-entry ping-pong column buffer.
// Define FMAP_SER_ABS_EN to convert negative values by magnitude instead of to 0.
module fmap_col_serializer #(
    parameter int PIX_H  = 24,
    parameter int PIX_W  = 24,
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    fmap_col_serializer_if.slave bus
);
    localparam int XW = $clog2(X_SIZE);
    localparam int YW = $clog2(Y_SIZE);
    localparam int RW = (PIX_H > 1) ? $clog2(PIX_H) : 1;
    localparam int CW = (PIX_W > 1) ? $clog2(PIX_W) : 1;

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nxt;

    logic [PIX_H-1:0][15:0] ent_col [2];
    logic [XW-1:0]          ent_x   [2];
    logic [YW-1:0]          ent_y   [2];
    logic [2:0]             ent_g   [2];
    logic [CW-1:0]          ent_idx [2];

    logic          wr_ptr, rd_ptr;
    logic [1:0]    count, count_nxt;
    logic [CW-1:0] col_idx;
    logic [RW-1:0] row;
    logic          col_ready, accept, load, out_free, last_row, free_head;

    logic          valid_q, eoc_q, eof_q;
    logic [7:0]    gray_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    // gray = floor(v * 2^g * 256), saturated to 255
    function automatic logic [7:0] to_gray(input logic [15:0] h, input logic [2:0] g);
        logic [5:0]  eg;
        logic [5:0]  sh;
        logic [10:0] m11;
        logic        neg;
        eg  = {1'b0, h[14:10]} + {3'b000, g};
        sh  = 6'd17 - eg;
        m11 = {1'b1, h[9:0]};
`ifdef FMAP_SER_ABS_EN
        neg = 1'b0;
`else
        neg = h[15];
`endif
        if (h[14:10] == 5'd0)       to_gray = 8'd0;
        else if (h[14:10] == 5'd31) to_gray = 8'hFF;
        else if (neg)               to_gray = 8'd0;
        else if (eg >= 6'd15)       to_gray = 8'hFF;
        else if (sh >= 6'd11)       to_gray = 8'd0;
        else                        to_gray = 8'(m11 >> sh);
    endfunction

    assign col_ready = (count < 2'd2);
    assign accept    = bus.col_valid && col_ready;
    assign out_free  = !valid_q || bus.pix_ready;
    assign last_row  = (row == RW'(PIX_H - 1));
    assign free_head = load && last_row;
    assign count_nxt = count + {1'b0, accept} - {1'b0, free_head};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count_nxt != 2'd0) state_nxt = SEND;
            SEND:    if (count_nxt == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        case (state)
            SEND:    load = out_free;
            default: load = 1'b0;
        endcase
    end

    // Entry payload needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_col[wr_ptr] <= bus.data_col;
            ent_x[wr_ptr]   <= bus.x_origin;
            ent_y[wr_ptr]   <= bus.y_origin;
            ent_g[wr_ptr]   <= bus.gain_shift;
            ent_idx[wr_ptr] <= col_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            col_idx <= '0;
            row     <= '0;
            valid_q <= 1'b0;
            gray_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            eoc_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            count <= count_nxt;
            if (accept) begin
                wr_ptr  <= ~wr_ptr;
                col_idx <= (col_idx == CW'(PIX_W - 1)) ? '0 : col_idx + CW'(1);
            end
            if (load) begin
                row <= last_row ? '0 : row + RW'(1);
                if (last_row) rd_ptr <= ~rd_ptr;
                gray_q <= to_gray(ent_col[rd_ptr][row], ent_g[rd_ptr]);
                x_q    <= ent_x[rd_ptr] + XW'(ent_idx[rd_ptr]);
                y_q    <= ent_y[rd_ptr] + YW'(row);
                eoc_q  <= last_row;
                eof_q  <= last_row && (ent_idx[rd_ptr] == CW'(PIX_W - 1));
            end
            if (out_free) valid_q <= load;
        end
    end

    assign bus.col_ready = col_ready;
    assign bus.pix_valid = valid_q;
    assign bus.pix_gray  = gray_q;
    assign bus.pix_x     = x_q;
    assign bus.pix_y     = y_q;
    assign bus.pix_eoc   = eoc_q;
    assign bus.pix_eof   = eof_q;
endmodule

// File: tb/tb_fmap_col_serializer.sv
// Bench for fmap_col_serializer: conversion table, hand sequences, random backpressure
// against a scoreboard fed by a value-level reference model.
module tb_fmap_col_serializer;
    localparam int PIX_H = 24;
    localparam int PIX_W = 4;
`ifdef FMAP_SER_ABS_EN
    localparam logic [7:0] NEG_HALF = 8'd128;
`else
    localparam logic [7:0] NEG_HALF = 8'd0;
`endif

    typedef struct packed {
        logic [7:0] gray;
        logic [9:0] x;
        logic [8:0] y;
        logic       eoc;
        logic       eof;
    } pix_t;

    typedef struct {
        logic [15:0] h;
        logic [2:0]  g;
        logic [7:0]  gray;
    } conv_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmap_col_serializer_if #(.PIX_H(PIX_H), .X_SIZE(640), .Y_SIZE(480)) bus ();
    fmap_col_serializer #(.PIX_H(PIX_H), .PIX_W(PIX_W), .X_SIZE(640), .Y_SIZE(480))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int   errors = 0;
    int   checks = 0;
    pix_t sb[$];
    pix_t got[$];
    int   idx_m = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
    int   run_len = 0;
    int   max_run = 0;
    bit   saw_full = 0;
    bit   prev_stall = 0;
    pix_t held;

    function automatic logic [7:0] ref_gray(input logic [15:0] h, input int g);
        int  e = int'(h[14:10]);
        int  m = int'(h[9:0]);
        int  k;
        real p = 1.0;
        real v;
        if (e == 0)  return 8'd0;
        if (e == 31) return 8'd255;
`ifndef FMAP_SER_ABS_EN
        if (h[15]) return 8'd0;
`endif
        // (1 + m/1024) * 2^(e-15) * 2^g * 256
        k = e + g - 17;
        if (k >= 0) repeat (k) p = p * 2.0;
        else        repeat (-k) p = p / 2.0;
        v = (1024.0 + real'(m)) * p;
        if (v >= 256.0) return 8'd255;
        return 8'($rtoi(v));
    endfunction

    function automatic pix_t cur_pix();
        return {bus.pix_gray, bus.pix_x, bus.pix_y, bus.pix_eoc, bus.pix_eof};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            run_len = 0;
            bus.pix_ready = 1'b1;
        end else begin
            if (prev_stall) begin
                checks++;
                if (cur_pix() !== held || bus.pix_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: got %0h expected %0h", cur_pix(), held);
                end
            end
            if (!bus.col_ready) saw_full = 1;
            case (ready_mode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = 1'($urandom_range(0, 1));
                default: bus.pix_ready = 1'b0;
            endcase
            if (bus.pix_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else run_len = 0;
            if (bus.pix_valid && bus.pix_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_unexpected: got %0h expected none", cur_pix());
                end else begin
                    pix_t e;
                    e = sb.pop_front();
                    if (cur_pix() !== e) begin
                        errors++;
                        $display("FAIL pixel: got %0h expected %0h", cur_pix(), e);
                    end
                end
                got.push_back(cur_pix());
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            held = cur_pix();
        end
    end

    task automatic send_col(input logic [PIX_H-1:0][15:0] col, input logic [9:0] xo,
                            input logic [8:0] yo, input logic [2:0] g);
        int   budget = 0;
        pix_t e;
        @(negedge clk);
        bus.col_valid  = 1'b1;
        bus.data_col   = col;
        bus.x_origin   = xo;
        bus.y_origin   = yo;
        bus.gain_shift = g;
        while (!bus.col_ready && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.col_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got col_ready=0 expected 1");
            bus.col_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int r = 0; r < PIX_H; r++) begin
            e.gray = ref_gray(col[r], int'(g));
            e.x    = 10'(int'(xo) + idx_m);
            e.y    = 9'(int'(yo) + r);
            e.eoc  = (r == PIX_H - 1);
            e.eof  = (r == PIX_H - 1) && (idx_m == PIX_W - 1);
            sb.push_back(e);
        end
        idx_m = (idx_m + 1) % PIX_W;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.col_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while ((sb.size() != 0 || bus.pix_valid) && b < 3000) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("drain_left", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.col_valid = 1'b0;
        sb.delete();
        got.delete();
        idx_m = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [PIX_H-1:0][15:0] rand_col();
        logic [PIX_H-1:0][15:0] c;
        for (int r = 0; r < PIX_H; r++) begin
            if ($urandom_range(0, 1) == 0) c[r] = 16'($urandom);
            else c[r] = {1'b0, 5'($urandom_range(6, 16)), 10'($urandom)};
        end
        return c;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        conv_vec_t              vec[10];
        logic [PIX_H-1:0][15:0] col;
        int                     eofs;

        vec[0] = '{16'h3C00, 3'd0, 8'd255};
        vec[1] = '{16'h3400, 3'd0, 8'd64};
        vec[2] = '{16'h1800, 3'd0, 8'd0};
        vec[3] = '{16'hB800, 3'd0, NEG_HALF};
        vec[4] = '{16'h7C00, 3'd0, 8'd255};
        vec[5] = '{16'h7E00, 3'd0, 8'd255};
        vec[6] = '{16'h0001, 3'd0, 8'd0};
        vec[7] = '{16'h3400, 3'd2, 8'd255};
        vec[8] = '{16'h3400, 3'd1, 8'd128};
        vec[9] = '{16'h3800, 3'd0, 8'd128};

        bus.col_valid = 1'b0;
        bus.data_col = '0;
        bus.x_origin = '0;
        bus.y_origin = '0;
        bus.gain_shift = '0;

        repeat (2) @(negedge clk);
        check("rst_col_ready", bus.col_ready, 1);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_pix_gray", bus.pix_gray, 0);
        check("rst_pix_x", bus.pix_x, 0);
        check("rst_pix_y", bus.pix_y, 0);
        check("rst_pix_eoc", bus.pix_eoc, 0);
        check("rst_pix_eof", bus.pix_eof, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // single 0.5 column, latency and coordinates
        col = {PIX_H{16'h3800}};
        send_col(col, 10'd100, 9'd50, 3'd0);
        @(negedge clk);
        bus.col_valid = 1'b0;
        check("latency_edge1", bus.pix_valid, 0);
        @(negedge clk);
        check("latency_edge2", bus.pix_valid, 1);
        drain();
        check("single_count", 64'(got.size()), PIX_H);
        if (got.size() == PIX_H) begin
            check("single_gray", got[0].gray, 8'd128);
            check("single_last_y", got[PIX_H-1].y, 9'd73);
            check("single_last_eoc", got[PIX_H-1].eoc, 1);
            check("single_mid_eoc", got[PIX_H-2].eoc, 0);
        end

        // conversion table
        for (int i = 0; i < 10; i++) begin
            got.delete();
            col = {PIX_H{vec[i].h}};
            send_col(col, 10'd0, 9'd0, vec[i].g);
            idle();
            drain();
            check($sformatf("conv_count_%0d", i), 64'(got.size()), PIX_H);
            if (got.size() > 0) check($sformatf("conv_gray_%0d", i), got[got.size()-1].gray, vec[i].gray);
        end

        // three back-to-back columns
        do_reset();
        max_run = 0;
        saw_full = 0;
        for (int i = 0; i < 3; i++) send_col(rand_col(), 10'd200, 9'd10, 3'($urandom_range(0, 7)));
        idle();
        drain();
        check("b2b_run", 64'(max_run), 3 * PIX_H);
        check("b2b_full_seen", saw_full, 1);
        if (got.size() == 3 * PIX_H) begin
            check("b2b_x0", got[0].x, 10'd200);
            check("b2b_x1", got[PIX_H].x, 10'd201);
            check("b2b_x2", got[2*PIX_H].x, 10'd202);
        end

        // five columns: eof and x wrap
        do_reset();
        for (int i = 0; i < 5; i++) send_col(rand_col(), 10'd1022, 9'd500, 3'd0);
        idle();
        drain();
        eofs = 0;
        foreach (got[i]) if (got[i].eof) eofs++;
        check("eof_count", 64'(eofs), 1);
        if (got.size() == 5 * PIX_H) begin
            check("eof_col3_last", got[4*PIX_H-1].eof, 1);
            check("wrap_x_idx2", got[2*PIX_H].x, 10'd0);
            check("col5_idx0_x", got[4*PIX_H].x, 10'd1022);
            check("wrap_y", got[12].y, 9'd0);
        end

        // random backpressure
        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            send_col(rand_col(), 10'($urandom), 9'($urandom), 3'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) idle();
        end
        idle();
        drain();

        // reset with a full buffer
        ready_mode = 2;
        send_col(rand_col(), 10'd5, 9'd5, 3'd0);
        send_col(rand_col(), 10'd5, 9'd5, 3'd0);
        idle();
        repeat (3) @(negedge clk);
        check("full_col_ready", bus.col_ready, 0);
        check("full_pix_valid", bus.pix_valid, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        got.delete();
        idx_m = 0;
        #1;
        check("mid_rst_col_ready", bus.col_ready, 1);
        check("mid_rst_pix_valid", bus.pix_valid, 0);
        check("mid_rst_outputs", {bus.pix_gray, bus.pix_x, bus.pix_y, bus.pix_eoc, bus.pix_eof}, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        ready_mode = 0;
        send_col(rand_col(), 10'd300, 9'd20, 3'd1);
        idle();
        drain();
        check("post_rst_count", 64'(got.size()), PIX_H);
        if (got.size() > 0) begin
            check("post_rst_x", got[0].x, 10'd300);
            check("post_rst_y", got[0].y, 9'd20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
